// File: rtl/demux1to2_buf_pkg.sv
// Datapath constants shared by the store-path fan-out blocks.
// Stream width and per-output buffer depth.
package demux1to2_buf_pkg;

    localparam int DP_WIDTH = 32;
    localparam int DP_DEPTH = 2;

endpackage

// File: rtl/demux1to2_buf_fifo_sync.sv
// Small synchronous FIFO: registered storage, read head driven from regs.
// Push is ignored when full and pop when empty; no bypass in either direction.
module fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CNT_FULL);
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign rdata  = r_mem[r_rptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_ONE;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/demux1to2_buf.sv
// Buffered 1:2 demux: one valid/ready producer fanned out to two sinks,
// each behind its own FIFO so a stalled sink never blocks the other.
module demux1to2_buf
    import demux1to2_buf_pkg::*;
#(
    parameter int WIDTH = DP_WIDTH,
    parameter int DEPTH = DP_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [$clog2(DEPTH+1)-1:0] out0_count,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH+1)-1:0] out1_count
);

    logic w_full0;
    logic w_full1;
    logic w_empty0;
    logic w_empty1;
    logic w_push0;
    logic w_push1;

    // Ready depends only on the selected FIFO's occupancy.
    assign in_ready   = in_sel ? !w_full1 : !w_full0;
    assign w_push0    = in_valid && in_ready && !in_sel;
    assign w_push1    = in_valid && in_ready && in_sel;
    assign out0_valid = !w_empty0;
    assign out1_valid = !w_empty1;

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push0),
        .wdata (in_data),
        .full  (w_full0),
        .pop   (out0_ready),
        .rdata (out0_data),
        .empty (w_empty0),
        .count (out0_count)
    );

    fifo_sync #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk   (clk),
        .reset (reset),
        .push  (w_push1),
        .wdata (in_data),
        .full  (w_full1),
        .pop   (out1_ready),
        .rdata (out1_data),
        .empty (w_empty1),
        .count (out1_count)
    );

endmodule

// File: tb/tb_demux1to2_buf.sv
// Bench for demux1to2_buf: table of per-cycle vectors with expected
// ready/counts, plus per-output queues scoring data order and latency.
module tb_demux1to2_buf;

    localparam int W  = 32;
    localparam int D  = 2;
    localparam int CW = $clog2(D+1);

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_sel;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out0_data;
    logic          out0_valid;
    logic          out0_ready;
    logic [CW-1:0] out0_count;
    logic [W-1:0]  out1_data;
    logic          out1_valid;
    logic          out1_ready;
    logic [CW-1:0] out1_count;

    demux1to2_buf #(.WIDTH(W), .DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_count (out0_count),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_count (out1_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         sel;
        logic [W-1:0] data;
        logic         valid;
        logic         r0;
        logic         r1;
        int           rdy;
        int           c0;
        int           c1;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    int           n_vec = 0;
    int           n_bad = 0;

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, check pre-edge outputs, advance the model.
    task automatic cycle(input vec_t v);
        logic m_rdy;
        logic p0;
        logic p1;
        @(negedge clk);
        in_sel     = v.sel;
        in_data    = v.data;
        in_valid   = v.valid;
        out0_ready = v.r0;
        out1_ready = v.r1;
        #1;
        m_rdy = v.sel ? (q1.size() < D) : (q0.size() < D);
        chk("in_ready", {31'd0, in_ready}, {31'd0, m_rdy});
        chk("out0_valid", {31'd0, out0_valid}, {31'd0, q0.size() != 0});
        chk("out1_valid", {31'd0, out1_valid}, {31'd0, q1.size() != 0});
        chk("out0_count", W'(out0_count), W'(q0.size()));
        chk("out1_count", W'(out1_count), W'(q1.size()));
        if (q0.size() != 0) chk("out0_data", out0_data, q0[0]);
        if (q1.size() != 0) chk("out1_data", out1_data, q1[0]);
        if (v.rdy >= 0) chk("tbl_rdy", {31'd0, in_ready}, W'(v.rdy));
        if (v.c0 >= 0) chk("tbl_c0", W'(out0_count), W'(v.c0));
        if (v.c1 >= 0) chk("tbl_c1", W'(out1_count), W'(v.c1));
        p0 = v.r0 && (q0.size() != 0);
        p1 = v.r1 && (q1.size() != 0);
        if (v.valid && m_rdy) begin
            if (v.sel) q1.push_back(v.data);
            else       q0.push_back(v.data);
        end
        if (p0) void'(q0.pop_front());
        if (p1) void'(q1.pop_front());
    endtask

    function automatic vec_t mk(input logic s, input logic [W-1:0] d,
                                input logic vl, input logic a, input logic b,
                                input int rdy, input int c0, input int c1);
        vec_t v;
        v.sel = s; v.data = d; v.valid = vl; v.r0 = a; v.r1 = b;
        v.rdy = rdy; v.c0 = c0; v.c1 = c1;
        return v;
    endfunction

    // Everything must read as freshly cleared after a reset.
    task automatic chk_cleared(input string tag);
        @(negedge clk);
        in_valid = 1'b0;
        in_sel   = 1'b0;
        #1;
        chk({tag, "_v0"}, {31'd0, out0_valid}, 32'd0);
        chk({tag, "_v1"}, {31'd0, out1_valid}, 32'd0);
        chk({tag, "_d0"}, out0_data, 32'h0000_0000);
        chk({tag, "_d1"}, out1_data, 32'h0000_0000);
        chk({tag, "_c0"}, W'(out0_count), 32'd0);
        chk({tag, "_c1"}, W'(out1_count), 32'd0);
        chk({tag, "_rdy0"}, {31'd0, in_ready}, 32'd1);
        in_sel = 1'b1;
        #1;
        chk({tag, "_rdy1"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_cleared("rst");

        // sel data valid r0 r1 | rdy c0 c1
        tbl.push_back(mk(0, 32'h0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 32'hAAAA_AAAA, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(1, 32'h5555_5555, 1, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 32'h0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 32'h1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(mk(0, 32'h2, 1, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 32'h9, 1, 0, 1, 0, 2, 0));
        tbl.push_back(mk(1, 32'h3, 1, 0, 1, 1, 2, 0));
        tbl.push_back(mk(0, 32'h4, 1, 1, 1, 0, 2, 1));
        tbl.push_back(mk(0, 32'h4, 0, 0, 1, 1, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 32'h0, 0, 1, 1, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) cycle(tbl[i]);

        // Streaming to output 1 across several pointer wraps.
        for (int i = 0; i < 8; i++) begin
            cycle(mk(1, 32'hC0DE_0000 + W'(i), 1, 1, 1, 1, 0, (i == 0) ? 0 : 1));
        end
        cycle(mk(1, 32'h0, 0, 1, 1, 1, 0, 1));
        cycle(mk(1, 32'h0, 0, 1, 1, 1, 0, 0));

        // Fill both outputs, then reset with a push still pending.
        cycle(mk(0, 32'hDEAD_0001, 1, 0, 0, 1, 0, 0));
        cycle(mk(1, 32'hDEAD_0002, 1, 0, 0, 1, 1, 0));
        cycle(mk(1, 32'hDEAD_0003, 1, 0, 0, 1, 1, 1));
        @(negedge clk);
        reset      = 1'b1;
        in_sel     = 1'b0;
        in_data    = 32'hBAD0_BAD0;
        in_valid   = 1'b1;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        @(posedge clk);
        q0.delete();
        q1.delete();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk_cleared("mid");
        cycle(mk(0, 32'h1234_5678, 1, 1, 1, 1, 0, 0));
        cycle(mk(0, 32'h0, 0, 1, 1, 1, 1, 0));
        cycle(mk(0, 32'h0, 0, 1, 1, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
